// File: rtl/log_mult_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// log_mult_seq
//
// Purpose:
//   Sequential Mitchell-approximation unsigned multiplier (8x8 -> 16).
//   A single leading-one detector is shared over time:
//     - it looks at operand A in one cycle,
//     - then at operand B in the next cycle.
//   The two logarithms are then added, and the sum is turned back into a
//   product by an antilog shift.
//   Timing, with the accept in cycle T: the product is presented from T+4
//   and is held until the consumer takes it.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operand pair valid
//   in_ready   out  high only in IDLE
//   a, b       in   unsigned operands (WIDTH bits)
//   out_valid  out  product valid (high in DONE)
//   out_ready  in   consumer accepts product
//   product    out  approximate a*b (2*WIDTH bits), 0 outside DONE
//   busy       out  high in any state other than IDLE
//
// Build option:
//   LOG_MULT_ZERO_BYPASS_EN
//     When defined, a zero operand found by the detector jumps straight to
//     DONE with product 0:
//       - a zero A gives out_valid at T+2,
//       - a zero B gives out_valid at T+3.
//     When undefined, zero operands take the full sequence.
// -----------------------------------------------------------------------------

// Leading-one detector.
//   k : position of the most significant set bit.
//   x : data normalised so that the leading one sits in bit 7; the fraction
//       is x[6:0].
module log_mult_lod (
    input  logic [7:0] i_data,
    output logic       o_zero,
    output logic [2:0] o_k,
    output logic [7:0] o_x
);
    always_comb begin
        o_zero = (i_data == 8'h00);
        o_k    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (i_data[i]) begin
                o_k = 3'(i);
            end
        end
        o_x = i_data << (3'd7 - o_k);
    end
endmodule

module log_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    // The shared detector is fixed at 8 bits, so no other width can work.
    if (WIDTH != 8) begin : g_bad_width
        $error("log_mult_seq: WIDTH must be 8");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOD_A = 3'd1,
        LOD_B = 3'd2,
        ADD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_za;
    logic             r_zb;
    logic [2:0]       r_ka;
    logic [2:0]       r_kb;
    logic [6:0]       r_xa;
    logic [6:0]       r_xb;
    logic [7:0]       r_s;
    logic [3:0]       r_ksum;
    logic             r_zero;

    logic [7:0]       w_lod_in;
    logic             w_lod_zero;
    logic [2:0]       w_lod_k;
    logic [7:0]       w_lod_x;
    logic             w_lod_is_zero;
    logic [7:0]       w_s;
    logic [3:0]       w_ksum;
    logic [15:0]      w_mant;
    logic [3:0]       w_exp;
    logic [15:0]      w_antilog;

    // ------------------------------------------------------------------
    // Shared detector.
    // Its input is steered to the latched operand only in the two
    // detection states; in every other state it sees zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_lod_in = 8'h00;
        case (r_state)
            LOD_A:   w_lod_in = r_a;
            LOD_B:   w_lod_in = r_b;
            default: w_lod_in = 8'h00;
        endcase
    end

    log_mult_lod u_lod (
        .i_data (w_lod_in),
        .o_zero (w_lod_zero),
        .o_k    (w_lod_k),
        .o_x    (w_lod_x)
    );

    // A normalised nonzero value always carries its leading one in bit 7.
    assign w_lod_is_zero = w_lod_zero | ~w_lod_x[7];

    // ------------------------------------------------------------------
    // Log-domain add.
    // Both fractions are 7 bits wide, so their sum fits in 8 bits.
    // Both exponents are at most 7, so their sum fits in 4 bits.
    // ------------------------------------------------------------------
    assign w_s    = {1'b0, r_xa} + {1'b0, r_xb};
    assign w_ksum = {1'b0, r_ka} + {1'b0, r_kb};

    // ------------------------------------------------------------------
    // Antilog.
    // The antilog is value = mant * 2^exp / 128, truncated.
    //   - No carry out of the fraction add: mant = 1.s[6:0], exp = ksum.
    //   - With a carry:                     mant = s,       exp = ksum + 1.
    // The left and right shifts are split on exp relative to 7. This gives
    // exactly the same result as the wide shift-left-then-right form, but no
    // bit is ever computed and then discarded.
    // Largest result: 254 << 8 = 65024.
    // ------------------------------------------------------------------
    always_comb begin
        w_mant = 16'd0;
        w_exp  = 4'd0;
        if (r_s[7]) begin
            w_mant = {8'd0, r_s};
            w_exp  = r_ksum + 4'd1;
        end else begin
            w_mant = {8'd0, 1'b1, r_s[6:0]};
            w_exp  = r_ksum;
        end

        if (w_exp >= 4'd7) begin
            w_antilog = w_mant << (w_exp - 4'd7);
        end else begin
            w_antilog = w_mant >> (4'd7 - w_exp);
        end
    end

    // ------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = LOD_A;
                end
            end
            LOD_A: begin
`ifdef LOG_MULT_ZERO_BYPASS_EN
                w_state_next = w_lod_is_zero ? DONE : LOD_B;
`else
                w_state_next = LOD_B;
`endif
            end
            LOD_B: begin
`ifdef LOG_MULT_ZERO_BYPASS_EN
                w_state_next = w_lod_is_zero ? DONE : ADD;
`else
                w_state_next = ADD;
`endif
            end
            ADD: begin
                w_state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers.
    // Everything is cleared on the way back to IDLE, so that a stale
    // result can never leak into the next operation.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_za   <= 1'b0;
            r_zb   <= 1'b0;
            r_ka   <= 3'd0;
            r_kb   <= 3'd0;
            r_xa   <= 7'd0;
            r_xb   <= 7'd0;
            r_s    <= 8'd0;
            r_ksum <= 4'd0;
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a <= a;
                        r_b <= b;
                    end
                end
                LOD_A: begin
                    r_za <= w_lod_is_zero;
                    r_ka <= w_lod_k;
                    r_xa <= w_lod_x[6:0];
`ifdef LOG_MULT_ZERO_BYPASS_EN
                    if (w_lod_is_zero) begin
                        r_zero <= 1'b1;
                    end
`endif
                end
                LOD_B: begin
                    r_zb <= w_lod_is_zero;
                    r_kb <= w_lod_k;
                    r_xb <= w_lod_x[6:0];
`ifdef LOG_MULT_ZERO_BYPASS_EN
                    if (w_lod_is_zero) begin
                        r_zero <= 1'b1;
                    end
`endif
                end
                ADD: begin
                    r_s    <= w_s;
                    r_ksum <= w_ksum;
                    r_zero <= r_za | r_zb;
                end
                DONE: begin
                    if (out_ready) begin
                        r_a    <= '0;
                        r_b    <= '0;
                        r_za   <= 1'b0;
                        r_zb   <= 1'b0;
                        r_ka   <= 3'd0;
                        r_kb   <= 3'd0;
                        r_xa   <= 7'd0;
                        r_xb   <= 7'd0;
                        r_s    <= 8'd0;
                        r_ksum <= 4'd0;
                        r_zero <= 1'b0;
                    end
                end
                default: begin
                    r_zero <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // All outputs are decoded from registered state and registered fields.
    // The product is therefore stable for the whole time DONE is held.
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign product   = (r_state == DONE && !r_zero) ? w_antilog : '0;

endmodule

// File: doc/log_mult_seq.md
Name: log_mult_seq

Overview:
- Sequential Mitchell-approximation 8x8 unsigned multiplier controller.
- Owns one shared leading-one detector (`lod`: data[7:0] -> zero_flag, k[2:0], x[7:0] with fraction in x[6:0]).
- Time-multiplexes that detector over operand A, then operand B, then performs log-domain add and antilog shift.
- Sits between an operand producer and a product consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand width; only 8 is legal (matches shared detector); product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept operands
- a  input  8  operand A, unsigned
- b  input  8  operand B, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  16  approximate A*B, unsigned
- busy  output  1  high in any state other than IDLE

Behaviour:
- One clock; reset is synchronous and active-high on rst.
- Reset state: IDLE. in_ready=1 (combinational from IDLE). out_valid=0, product=0, busy=0. All internal registers cleared.
- Reset mid-operation discards the operation; no partial product is emitted.
- FSM states:
  - IDLE: in_ready=1. When in_valid&&in_ready (accept, cycle T), latch a and b and go to LOD_A.
  - LOD_A (T+1): detector input = latched A. Register za, ka, xa=x[6:0]. Go to LOD_B.
  - LOD_B (T+2): detector input = latched B. Register zb, kb, xb. Go to ADD.
  - ADD (T+3): s[7:0] = xa + xb; ksum[3:0] = ka + kb; zero = za|zb. Register all three. Go to DONE.
  - DONE (T+4 onward): product and out_valid=1 are driven from registers. Go to IDLE in the cycle out_valid&&out_ready. Hold product stable until then.
- Operand inputs are ignored outside the accept cycle. in_ready=0 in every state except IDLE. No back-to-back overlap; throughput is one product per 5 cycles at best.
- Detector input is 8'h00 in states other than LOD_A and LOD_B.
- Antilog, computed in the ADD to DONE transition (truncating, no rounding):
  - zero=1: product = 0.
  - s[7]=0: product = ({1'b1, s[6:0]} << ksum) >> 7.
  - s[7]=1: product = (s << (ksum+1)) >> 7.
  - Intermediates are at least 23 bits wide; the result always fits in 16 bits (max 65024).
- out_valid falls in the cycle after the output handshake. product is cleared to 0 when returning to IDLE.
- If out_ready is already high when DONE is entered, the product is transferred that cycle; out_valid is high for exactly one cycle.

Optional Feature:
- Macro: LOG_MULT_ZERO_BYPASS_EN
- Defined:
  - In LOD_A, if the detector reports zero_flag for A, go directly to DONE with product=0 (out_valid at T+2).
  - In LOD_B, if zero_flag for B, go directly to DONE with product=0 (out_valid at T+3).
- Undefined: zero operands take the full sequence (out_valid at T+4, product=0).
- Nonzero latency and all results are identical in both builds.

Test Plan:
- Reset, then a=3, b=3 accepted at T, out_ready=1 -> in_ready=0 T+1..T+4; out_valid=1 at T+4 only; product=8; then IDLE with in_ready=1.
- Pairs 255x255, 1x200, 16x16, 5x6 -> products 65024, 200, 256, 28 respectively, each at T+4 (carry and no-carry paths).
- a=0, b=77 and a=77, b=0 -> product=0. Bypass build: out_valid at T+2 and T+3 respectively. Non-bypass build: T+4 in both cases.
- out_ready held low 10 cycles in DONE; a, b, in_valid toggled meanwhile -> out_valid and product=28 (5x6) held stable, in_ready=0, new operands ignored. Release out_ready -> one transfer, then IDLE.
- rst asserted in LOD_B -> next cycle out_valid=0, product=0, busy=0, in_ready=1. A fresh 3x3 then returns 8 at T+4.
- in_valid held high continuously with changing operands -> only one accept per pass through IDLE. Each product matches the operands sampled at its accept cycle.
